// File: rtl/leaf_dispatch_pkg.sv
// Shared constants and index/credit typedefs for leaf_dispatch levels.
// Sizes derive from the default level shape. Each level instance resizes its own signals from its parameters.
package leaf_dispatch_pkg;

    localparam int NUM_LEAVES_DEF = 10;
    localparam int CREDITS_DEF    = 2;
    localparam int STAT_W         = 16;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [idx_width(NUM_LEAVES_DEF)-1:0] leaf_idx_t;
    typedef logic [$clog2(CREDITS_DEF+1)-1:0]     credit_t;

endpackage

// File: rtl/leaf_dispatch_rr_pick.sv
// Round-robin target picker: first leaf at or after i_rr_ptr (wrapping) whose credit is nonzero.
// Purely combinational so sibling levels can reuse it with their own credit bookkeeping.
module leaf_rr_pick
    import leaf_dispatch_pkg::*;
#(
    parameter int N     = NUM_LEAVES_DEF,
    parameter int IDX_W = idx_width(NUM_LEAVES_DEF)
) (
    input  logic [N-1:0]     i_nz,
    input  logic [IDX_W-1:0] i_rr_ptr,
    output logic [IDX_W-1:0] o_tgt,
    output logic             o_any
);

    logic [IDX_W:0] w_sum;

    always_comb begin
        o_tgt = i_rr_ptr;
        o_any = |i_nz;
        w_sum = '0;
        // Scan farthest offset first so the nearest eligible leaf is the last one to be written.
        for (int k = N - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_rr_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(N)) begin
                w_sum = w_sum - (IDX_W+1)'(N);
            end
            if (i_nz[w_sum[IDX_W-1:0]]) begin
                o_tgt = w_sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/leaf_dispatch.sv
// Round-robin, credit-gated dispatcher feeding NUM_LEAVES children from one stream through a one-beat output register.
// Optional per-leaf beat counters (stat_beats) are built when LEAF_DISPATCH_STATS_EN is defined.
module leaf_dispatch
    import leaf_dispatch_pkg::*;
#(
    parameter int NUM_LEAVES = NUM_LEAVES_DEF,
    parameter int DATA_W     = 32,
    parameter int CREDITS    = CREDITS_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic [NUM_LEAVES-1:0]    out_valid,
    input  logic [NUM_LEAVES-1:0]    out_ready,
    output logic [DATA_W-1:0]        out_data,
    input  logic [NUM_LEAVES-1:0]    credit_return,
`ifdef LEAF_DISPATCH_STATS_EN
    output logic [NUM_LEAVES*STAT_W-1:0] stat_beats,
`endif
    output logic                     busy,
    output logic                     err_credit_ovf
);

    localparam int IDX_W = idx_width(NUM_LEAVES);
    localparam int CW    = $clog2(CREDITS + 1);
    localparam logic [CW-1:0]    CRED_MAX = CW'(CREDITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEAVES - 1);

    logic                  r_held;
    logic [IDX_W-1:0]      r_held_tgt;
    logic [DATA_W-1:0]     r_data;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic [CW-1:0]         r_credit [NUM_LEAVES];
    logic                  r_err;

    logic [NUM_LEAVES-1:0] w_nz;
    logic [NUM_LEAVES-1:0] w_dec;
    logic [NUM_LEAVES-1:0] w_ovf;
    logic [NUM_LEAVES-1:0] w_out_valid;
    logic [IDX_W-1:0]      w_tgt;
    logic                  w_any;
    logic                  w_out_fire;
    logic                  w_accept;

    always_comb begin
        w_nz        = '0;
        w_out_valid = '0;
        for (int i = 0; i < NUM_LEAVES; i++) begin
            w_nz[i]        = (r_credit[i] != '0);
            w_out_valid[i] = r_held && (r_held_tgt == IDX_W'(i));
        end
    end

    leaf_rr_pick #(
        .N     (NUM_LEAVES),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_nz     (w_nz),
        .i_rr_ptr (r_rr_ptr),
        .o_tgt    (w_tgt),
        .o_any    (w_any)
    );

    // Handshake: a beat moves when valid && ready on the same rising edge. A valid beat
    // keeps its data and target until taken. in_ready depends only on registered credits
    // and the held leaf's out_ready, never on credit_return.
    assign w_out_fire = |(w_out_valid & out_ready);
    assign in_ready   = w_any && (!r_held || w_out_fire);
    assign w_accept   = in_valid && in_ready;

    always_comb begin
        w_dec = '0;
        w_ovf = '0;
        for (int i = 0; i < NUM_LEAVES; i++) begin
            w_dec[i] = w_accept && (w_tgt == IDX_W'(i));
            w_ovf[i] = credit_return[i] && !w_dec[i] && (r_credit[i] == CRED_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_held     <= 1'b0;
            r_held_tgt <= '0;
            r_data     <= '0;
            r_rr_ptr   <= '0;
            r_err      <= 1'b0;
            for (int i = 0; i < NUM_LEAVES; i++) begin
                r_credit[i] <= CRED_MAX;
            end
        end else begin
            if (w_accept) begin
                r_held     <= 1'b1;
                r_held_tgt <= w_tgt;
                r_data     <= in_data;
                r_rr_ptr   <= (w_tgt == LAST_IDX) ? '0 : w_tgt + IDX_W'(1);
            end else if (w_out_fire) begin
                r_held <= 1'b0;
            end
            // Credit is reserved at accept; a same-cycle return cancels the decrement.
            for (int i = 0; i < NUM_LEAVES; i++) begin
                if (w_dec[i] && !credit_return[i]) begin
                    r_credit[i] <= r_credit[i] - CW'(1);
                end else if (credit_return[i] && !w_dec[i] && (r_credit[i] != CRED_MAX)) begin
                    r_credit[i] <= r_credit[i] + CW'(1);
                end
            end
            if (|w_ovf) begin
                r_err <= 1'b1;
            end
        end
    end

    assign out_valid      = w_out_valid;
    assign out_data       = r_data;
    assign busy           = r_held;
    assign err_credit_ovf = r_err;

`ifdef LEAF_DISPATCH_STATS_EN
    logic [STAT_W-1:0] r_stat [NUM_LEAVES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LEAVES; i++) begin
                r_stat[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LEAVES; i++) begin
                if (w_out_valid[i] && out_ready[i] && (r_stat[i] != {STAT_W{1'b1}})) begin
                    r_stat[i] <= r_stat[i] + STAT_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_LEAVES; g++) begin : g_stat
        assign stat_beats[g*STAT_W +: STAT_W] = r_stat[g];
    end
`endif

endmodule

// File: tb/tb_leaf_dispatch.sv
// Directed self-checking bench for leaf_dispatch (NUM_LEAVES=10, DATA_W=8, CREDITS=2).
// Inputs change and outputs are sampled one or two time units after the rising edge.
module tb_leaf_dispatch;

    localparam int NL = 10;
    localparam int DW = 8;
    localparam int CR = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [NL-1:0] out_valid;
    logic [NL-1:0] out_ready = '0;
    logic [DW-1:0] out_data;
    logic [NL-1:0] credit_return = '0;
    logic          busy;
    logic          err_credit_ovf;
`ifdef LEAF_DISPATCH_STATS_EN
    logic [NL*16-1:0] stat_beats;
`endif

    int total = 0;
    int bad   = 0;
    int acc;
    logic [DW-1:0] exp_q[$];

    leaf_dispatch #(
        .NUM_LEAVES (NL),
        .DATA_W     (DW),
        .CREDITS    (CR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .credit_return  (credit_return),
`ifdef LEAF_DISPATCH_STATS_EN
        .stat_beats     (stat_beats),
`endif
        .busy           (busy),
        .err_credit_ovf (err_credit_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        in_valid      = 1'b0;
        credit_return = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Offer one beat that must be accepted now and appear on 'leaf' one cycle later.
    task automatic send(input string tag, input logic [DW-1:0] d, input int leaf);
        logic [NL-1:0] m;
        m       = '0;
        m[leaf] = 1'b1;
        in_valid = 1'b1;
        in_data  = d;
        #1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(m));
        chk({tag, "_out_data"}, 32'(out_data), 32'(d));
    endtask

    task automatic pulse_return(input logic [NL-1:0] mask);
        credit_return = mask;
        tick();
        credit_return = '0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_err", 32'(err_credit_ovf), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // 1: back-to-back stream, beat k on leaf k one cycle after accept
        out_ready = '1;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hA0 + k);
            #1;
            chk("t1_in_ready", 32'(in_ready), 32'd1);
            if (k > 0) begin
                chk("t1_out_valid", 32'(out_valid), 32'd1 << (k - 1));
                chk("t1_out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
            exp_q.push_back(in_data);
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("t1_out_valid_last", 32'(out_valid), 32'd1 << 9);
        chk("t1_out_data_last", 32'(out_data), 32'(exp_q.pop_front()));
        chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // 2: credits exhaust after 20 beats; a returned credit is usable next cycle
        do_reset();
        out_ready = '1;
        acc = 0;
        for (int n = 0; n < 25; n++) begin
            in_valid = 1'b1;
            in_data  = 8'(acc);
            #1;
            chk("t2_in_ready", 32'(in_ready), 32'(n < 20));
            if (in_ready) acc++;
            tick();
        end
        chk("t2_accepted", 32'(acc), 32'd20);
        in_data       = 8'h77;
        credit_return = 10'b1 << 3;
        #1;
        chk("t2_no_comb_return", 32'(in_ready), 32'd0);
        tick();
        credit_return = '0;
        #1;
        chk("t2_ready_after_return", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("t2_leaf3_valid", 32'(out_valid), 32'd1 << 3);
        chk("t2_leaf3_data", 32'(out_data), 32'h77);

        // 3: stalled leaf 0 holds its beat; release lets the next beat go to leaf 1
        do_reset();
        out_ready = 10'h3FE;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        #1;
        chk("t3_first_ready", 32'(in_ready), 32'd1);
        tick();
        in_data = 8'h66;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t3_stall_ready", 32'(in_ready), 32'd0);
            chk("t3_stall_valid", 32'(out_valid), 32'd1);
            chk("t3_stall_data", 32'(out_data), 32'h55);
            tick();
        end
        out_ready = '1;
        #1;
        chk("t3_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("t3_leaf1_valid", 32'(out_valid), 32'd1 << 1);
        chk("t3_leaf1_data", 32'(out_data), 32'h66);

        // 4: skip a creditless leaf; pointer lands after the chosen leaf
        do_reset();
        out_ready = '1;
        for (int i = 0; i < 20; i++) send("t4_drain", 8'(i), i % 10);
        in_valid = 1'b1;
        #1;
        chk("t4_empty_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        pulse_return(10'b00_0000_0101);
        send("t4_leaf0", 8'h40, 0);
        send("t4_skip1", 8'h41, 2);
        pulse_return(10'b00_0000_1110);
        send("t4_ptr3", 8'h42, 3);

        // 5: overflow is sticky until reset; simultaneous accept+return leaves count unchanged
        do_reset();
        chk("t5_err_init", 32'(err_credit_ovf), 32'd0);
        pulse_return(10'b1 << 5);
        #1;
        chk("t5_err_set", 32'(err_credit_ovf), 32'd1);
        send("t5_traffic_a", 8'h11, 0);
        send("t5_traffic_b", 8'h12, 1);
        chk("t5_err_sticky", 32'(err_credit_ovf), 32'd1);
        do_reset();
        chk("t5_err_cleared", 32'(err_credit_ovf), 32'd0);
        in_valid      = 1'b1;
        in_data       = 8'h13;
        credit_return = 10'b1;
        #1;
        chk("t5_same_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid      = 1'b0;
        credit_return = '0;
        #1;
        chk("t5_same_valid", 32'(out_valid), 32'd1);
        chk("t5_same_no_err", 32'(err_credit_ovf), 32'd0);
        pulse_return(10'b1);
        #1;
        chk("t5_same_still_full", 32'(err_credit_ovf), 32'd1);

        // 6: mid-operation reset drops the held beat and restores credits and pointer
        do_reset();
        out_ready = '0;
        in_valid  = 1'b1;
        in_data   = 8'h21;
        #1;
        chk("t6_accept", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("t6_busy_held", 32'(busy), 32'd1);
        chk("t6_valid_held", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t6_valid_after_rst", 32'(out_valid), 32'd0);
        chk("t6_busy_after_rst", 32'(busy), 32'd0);
        chk("t6_data_after_rst", 32'(out_data), 32'd0);
        out_ready = '1;
        for (int i = 0; i < 20; i++) send("t6_refill", 8'(8'h30 + i), i % 10);
        in_valid = 1'b1;
        #1;
        chk("t6_full_credits_used", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
